// File: rtl/issue_credit_ctrl.sv
// In-order N-way issue gate: per-station and ROB free-slot credits decide which decoded
// ways may issue this cycle; any refused valid way raises stop to hold the front end.

module issue_credit_cnt #(
  parameter int DEPTH = 8,
  parameter int W     = 4,
  parameter int RLW   = 2,
  parameter int GW    = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  input  logic [GW-1:0]  take,
  input  logic [RLW-1:0] rel,
  output logic [W-1:0]   cred,
  output logic           ovf
);
  // Wide enough for a full counter plus the largest release, so overflow is visible.
  localparam int NW = $clog2(DEPTH + (1 << RLW) + 1);

  logic [NW-1:0] nxt;

  // take never exceeds cred (grant rule), so the subtraction cannot wrap.
  assign nxt = NW'(cred) - NW'(take) + NW'(rel);
  assign ovf = !flush && (nxt > NW'(DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      cred <= W'(DEPTH);
    else if (flush) cred <= W'(DEPTH);
    else if (ovf)   cred <= W'(DEPTH);
    else            cred <= W'(nxt);
  end
endmodule

module issue_credit_ctrl #(
  parameter int ISSUE_WIDTH = 2,
  parameter int NUM_ST      = 3,
  parameter int ST_DEPTH    = 8,
  parameter int ROB_DEPTH   = 16,
  parameter int MAX_REL     = 2,
  localparam int STW = (NUM_ST > 1) ? $clog2(NUM_ST) : 1,
  localparam int CW  = $clog2(ST_DEPTH + 1),
  localparam int RCW = $clog2(ROB_DEPTH + 1),
  localparam int RLW = $clog2(MAX_REL + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [ISSUE_WIDTH-1:0]     instr_valid,
  input  logic [ISSUE_WIDTH*STW-1:0] instr_st,
  input  logic [NUM_ST*RLW-1:0]      st_release,
  input  logic [RLW-1:0]             rob_retire,
  output logic [ISSUE_WIDTH-1:0]     issue_grant,
  output logic                       stop,
  output logic [NUM_ST*CW-1:0]       st_credit,
  output logic [RCW-1:0]             rob_credit,
  output logic                       credit_err
);
  localparam int GW = $clog2(ISSUE_WIDTH + 1);

  logic [ISSUE_WIDTH-1:0][STW-1:0] way_st;
  logic [NUM_ST-1:0][RLW-1:0]      rel;
  logic [NUM_ST-1:0][CW-1:0]       st_cred;
  logic [NUM_ST-1:0][GW-1:0]       st_take;
  logic [NUM_ST-1:0]               st_ovf;
  logic [GW-1:0]                   rob_take;
  logic [RCW-1:0]                  rob_cred;
  logic                            rob_ovf;
  logic [ISSUE_WIDTH-1:0]          grant;
  logic                            blocked;
  logic                            room;

  assign way_st     = instr_st;
  assign rel        = st_release;
  assign st_credit  = st_cred;
  assign rob_credit = rob_cred;

  // Walk the ways in order; a refusal blocks every higher way. Out-of-range
  // station indices match no station and so are always refused.
  always_comb begin
    grant    = '0;
    st_take  = '0;
    rob_take = '0;
    blocked  = 1'b0;
    room     = 1'b0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      room = 1'b0;
      for (int s = 0; s < NUM_ST; s++)
        if (32'(way_st[i]) == s && 32'(st_cred[s]) > 32'(st_take[s])) room = 1'b1;
      if (32'(rob_cred) <= 32'(rob_take)) room = 1'b0;
      if (instr_valid[i] && !blocked) begin
        if (room) begin
          grant[i] = 1'b1;
          rob_take = rob_take + 1'b1;
          for (int s = 0; s < NUM_ST; s++)
            if (32'(way_st[i]) == s) st_take[s] = st_take[s] + 1'b1;
        end else begin
          blocked = 1'b1;
        end
      end
    end
    if (reset || flush) grant = '0;
  end

  assign issue_grant = grant;
  assign stop        = (|(instr_valid & ~grant)) && !reset && !flush;

  generate
    for (genvar s = 0; s < NUM_ST; s++) begin : g_st
      issue_credit_cnt #(.DEPTH(ST_DEPTH), .W(CW), .RLW(RLW), .GW(GW)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .take  (st_take[s]),
        .rel   (rel[s]),
        .cred  (st_cred[s]),
        .ovf   (st_ovf[s])
      );
    end
  endgenerate

  issue_credit_cnt #(.DEPTH(ROB_DEPTH), .W(RCW), .RLW(RLW), .GW(GW)) u_rob (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .take  (rob_take),
    .rel   (rob_retire),
    .cred  (rob_cred),
    .ovf   (rob_ovf)
  );

  // Sticky until reset; flush deliberately leaves it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     credit_err <= 1'b0;
    else if (|st_ovf || rob_ovf)   credit_err <= 1'b1;
  end
endmodule

// File: tb/tb_issue_credit_ctrl.sv
// Bench for issue_credit_ctrl: directed scenarios plus random traffic against a
// per-cycle credit model derived from the issue rules.

module tb_issue_credit_ctrl;
  localparam int NS = 3, SD = 8, RD = 16, CW = 4, RCW = 5;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic [1:0]  instr_valid;
  logic [3:0]  instr_st;
  logic [5:0]  st_release;
  logic [1:0]  rob_retire;
  logic [1:0]  issue_grant;
  logic        stop;
  logic [11:0] st_credit;
  logic [4:0]  rob_credit;
  logic        credit_err;

  issue_credit_ctrl dut (
    .clk(clk), .reset(reset), .flush(flush), .instr_valid(instr_valid),
    .instr_st(instr_st), .st_release(st_release), .rob_retire(rob_retire),
    .issue_grant(issue_grant), .stop(stop), .st_credit(st_credit),
    .rob_credit(rob_credit), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int m_st[NS];
  int m_rob;
  bit m_err;
  logic [1:0] exp_grant, obs_grant;
  logic       exp_stop, obs_stop;

  // Reference: ways in order; a way issues when its station and the ROB still have room
  // after the earlier grants of this cycle; first refusal stops all later ways.
  function automatic void predict(input logic [1:0] v, input int s0, input int s1, input logic fl);
    int sts[2];
    int used[NS];
    int tot;
    bit blk;
    sts[0] = s0; sts[1] = s1;
    foreach (used[k]) used[k] = 0;
    tot = 0; blk = 0;
    exp_grant = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (v[i]) begin
        if (!blk && sts[i] < NS && m_st[sts[i]] > used[sts[i]] && m_rob > tot) begin
          exp_grant[i] = 1'b1;
          used[sts[i]]++;
          tot++;
        end else blk = 1;
      end
    end
    exp_stop = ((v & ~exp_grant) != 2'b00);
    if (fl) begin exp_grant = 2'b00; exp_stop = 1'b0; end
  endfunction

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; instr_valid = 2'b11; instr_st = 4'b0100;
    st_release = '0; rob_retire = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; instr_valid = 2'b00;
    foreach (m_st[s]) m_st[s] = SD;
    m_rob = RD; m_err = 0;
  endtask

  // Drive one cycle (called at posedge+1), sample combinational outputs mid-cycle,
  // then advance the model across the edge.
  task automatic cyc(input logic [1:0] v, input int s0, input int s1,
                     input int r0, input int r1, input int r2, input int rr, input logic fl);
    int rel[NS];
    int sts[2];
    int v2;
    instr_valid = v; instr_st = {2'(s1), 2'(s0)};
    st_release = {2'(r2), 2'(r1), 2'(r0)}; rob_retire = 2'(rr); flush = fl;
    predict(v, s0, s1, fl);
    @(negedge clk);
    obs_grant = issue_grant; obs_stop = stop;
    @(posedge clk); #1;
    rel[0] = r0; rel[1] = r1; rel[2] = r2; sts[0] = s0; sts[1] = s1;
    if (fl) begin
      foreach (m_st[s]) m_st[s] = SD;
      m_rob = RD;
    end else begin
      for (int s = 0; s < NS; s++) begin
        v2 = m_st[s] + rel[s];
        for (int i = 0; i < 2; i++) if (exp_grant[i] && sts[i] == s) v2--;
        if (v2 > SD) begin v2 = SD; m_err = 1; end
        m_st[s] = v2;
      end
      v2 = m_rob + rr - int'(exp_grant[0]) - int'(exp_grant[1]);
      if (v2 > RD) begin v2 = RD; m_err = 1; end
      m_rob = v2;
    end
    instr_valid = 2'b00; flush = 1'b0; st_release = '0; rob_retire = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; instr_valid = 2'b11; instr_st = 4'b0100; flush = 1'b0;
    st_release = '0; rob_retire = '0;
    #3;
    total++; if (issue_grant !== 2'b00 || stop !== 1'b0) begin bad++;
      $display("FAIL reset_outputs grant=%b stop=%b exp grant=00 stop=0", issue_grant, stop); end
    do_reset();
    total++; if (st_credit !== {4'd8, 4'd8, 4'd8} || rob_credit !== 5'd16 || credit_err !== 1'b0) begin bad++;
      $display("FAIL reset_credits st=%h rob=%0d err=%b exp st=888 rob=16 err=0", st_credit, rob_credit, credit_err); end
    cyc(2'b11, 0, 1, 0, 0, 0, 0, 1'b0);
    // async reset mid-cycle with valid ways pending
    instr_valid = 2'b11; #2 reset = 1'b1; #1;
    total++; if (st_credit !== {4'd8, 4'd8, 4'd8} || rob_credit !== 5'd16 || issue_grant !== 2'b00 || stop !== 1'b0) begin bad++;
      $display("FAIL midcycle_reset st=%h rob=%0d grant=%b stop=%b", st_credit, rob_credit, issue_grant, stop); end
    @(posedge clk); #1 reset = 1'b0; instr_valid = 2'b00;
    foreach (m_st[s]) m_st[s] = SD;
    m_rob = RD; m_err = 0;
  endtask

  task automatic test_basic();
    do_reset();
    cyc(2'b11, 0, 1, 0, 0, 0, 0, 1'b0);
    total++; if (obs_grant !== 2'b11 || obs_stop !== 1'b0) begin bad++;
      $display("FAIL basic_grant grant=%b stop=%b exp grant=11 stop=0", obs_grant, obs_stop); end
    total++; if (st_credit[3:0] !== 4'd7 || st_credit[7:4] !== 4'd7 || st_credit[11:8] !== 4'd8 || rob_credit !== 5'd14) begin bad++;
      $display("FAIL basic_credits st=%h rob=%0d exp st=877 rob=14", st_credit, rob_credit); end
  endtask

  task automatic test_drain();
    do_reset();
    repeat (4) cyc(2'b11, 0, 0, 0, 0, 0, 0, 1'b0);
    total++; if (st_credit[3:0] !== 4'd0 || rob_credit !== 5'd8) begin bad++;
      $display("FAIL drain_credit st0=%0d rob=%0d exp st0=0 rob=8", st_credit[3:0], rob_credit); end
    cyc(2'b11, 0, 0, 0, 0, 0, 0, 1'b0);
    total++; if (obs_grant !== 2'b00 || obs_stop !== 1'b1) begin bad++;
      $display("FAIL drain_refuse grant=%b stop=%b exp grant=00 stop=1", obs_grant, obs_stop); end
    total++; if (st_credit[3:0] !== 4'd0 || rob_credit !== 5'd8) begin bad++;
      $display("FAIL drain_hold st0=%0d rob=%0d exp st0=0 rob=8", st_credit[3:0], rob_credit); end
  endtask

  task automatic test_partial();
    do_reset();
    repeat (3) cyc(2'b11, 0, 0, 0, 0, 0, 0, 1'b0);
    cyc(2'b01, 0, 0, 0, 0, 0, 0, 1'b0);
    cyc(2'b11, 0, 0, 0, 0, 0, 0, 1'b0);
    total++; if (obs_grant !== 2'b01 || obs_stop !== 1'b1) begin bad++;
      $display("FAIL partial_grant grant=%b stop=%b exp grant=01 stop=1", obs_grant, obs_stop); end
    total++; if (st_credit[3:0] !== 4'd0 || rob_credit !== 5'd8) begin bad++;
      $display("FAIL partial_credit st0=%0d rob=%0d exp st0=0 rob=8", st_credit[3:0], rob_credit); end
  endtask

  task automatic test_order();
    do_reset();
    repeat (4) cyc(2'b11, 2, 2, 0, 0, 0, 0, 1'b0);
    cyc(2'b11, 2, 1, 0, 0, 0, 0, 1'b0);
    total++; if (obs_grant !== 2'b00 || obs_stop !== 1'b1) begin bad++;
      $display("FAIL order_block grant=%b stop=%b exp grant=00 stop=1", obs_grant, obs_stop); end
    cyc(2'b10, 2, 1, 0, 0, 0, 0, 1'b0);
    total++; if (obs_grant !== 2'b10 || obs_stop !== 1'b0) begin bad++;
      $display("FAIL order_bubble grant=%b stop=%b exp grant=10 stop=0", obs_grant, obs_stop); end
    cyc(2'b11, 3, 1, 0, 0, 0, 0, 1'b0);
    total++; if (obs_grant !== 2'b00 || obs_stop !== 1'b1) begin bad++;
      $display("FAIL bad_station grant=%b stop=%b exp grant=00 stop=1", obs_grant, obs_stop); end
    total++; if (st_credit[7:4] !== 4'd7 || rob_credit !== 5'd7) begin bad++;
      $display("FAIL order_credit st1=%0d rob=%0d exp st1=7 rob=7", st_credit[7:4], rob_credit); end
  endtask

  task automatic test_no_bypass();
    do_reset();
    repeat (4) cyc(2'b11, 0, 0, 0, 0, 0, 0, 1'b0);
    cyc(2'b01, 0, 0, 2, 0, 0, 0, 1'b0);
    total++; if (obs_grant !== 2'b00 || obs_stop !== 1'b1) begin bad++;
      $display("FAIL nobypass_grant grant=%b stop=%b exp grant=00 stop=1", obs_grant, obs_stop); end
    total++; if (st_credit[3:0] !== 4'd2) begin bad++;
      $display("FAIL nobypass_credit st0=%0d exp 2", st_credit[3:0]); end
    cyc(2'b01, 0, 0, 0, 0, 0, 0, 1'b0);
    total++; if (obs_grant !== 2'b01 || st_credit[3:0] !== 4'd1) begin bad++;
      $display("FAIL nobypass_use grant=%b st0=%0d exp grant=01 st0=1", obs_grant, st_credit[3:0]); end
  endtask

  task automatic test_overflow_flush();
    do_reset();
    cyc(2'b00, 0, 0, 0, 1, 0, 0, 1'b0);
    total++; if (st_credit[7:4] !== 4'd8 || credit_err !== 1'b1) begin bad++;
      $display("FAIL overflow st1=%0d err=%b exp st1=8 err=1", st_credit[7:4], credit_err); end
    cyc(2'b11, 0, 2, 0, 0, 0, 0, 1'b0);
    cyc(2'b11, 1, 2, 0, 0, 0, 0, 1'b0);
    total++; if (credit_err !== 1'b1 || st_credit !== {4'd6, 4'd7, 4'd7}) begin bad++;
      $display("FAIL err_sticky err=%b st=%h exp err=1 st=677", credit_err, st_credit); end
    cyc(2'b11, 0, 1, 1, 1, 1, 1, 1'b1);
    total++; if (obs_grant !== 2'b00 || obs_stop !== 1'b0) begin bad++;
      $display("FAIL flush_outputs grant=%b stop=%b exp grant=00 stop=0", obs_grant, obs_stop); end
    total++; if (st_credit !== {4'd8, 4'd8, 4'd8} || rob_credit !== 5'd16 || credit_err !== 1'b1) begin bad++;
      $display("FAIL flush_reload st=%h rob=%0d err=%b exp st=888 rob=16 err=1", st_credit, rob_credit, credit_err); end
  endtask

  task automatic test_random();
    logic [1:0] v;
    int s0, s1, r[NS], rr;
    logic fl;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      v  = 2'($urandom_range(0, 3));
      s0 = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      s1 = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      for (int s = 0; s < NS; s++) begin
        r[s] = $urandom_range(0, 2);
        if (r[s] > SD - m_st[s]) r[s] = SD - m_st[s];
      end
      rr = $urandom_range(0, 2);
      if (rr > RD - m_rob) rr = RD - m_rob;
      fl = ($urandom_range(0, 49) == 0);
      cyc(v, s0, s1, r[0], r[1], r[2], rr, fl);
      total++; if (obs_grant !== exp_grant || obs_stop !== exp_stop) begin bad++;
        $display("FAIL rand_grant n=%0d grant=%b stop=%b exp grant=%b stop=%b", n, obs_grant, obs_stop, exp_grant, exp_stop); end
      total++; if (st_credit !== {CW'(m_st[2]), CW'(m_st[1]), CW'(m_st[0])} || rob_credit !== RCW'(m_rob) || credit_err !== m_err) begin bad++;
        $display("FAIL rand_credit n=%0d st=%h rob=%0d err=%b exp st=%0d,%0d,%0d rob=%0d err=%b",
                 n, st_credit, rob_credit, credit_err, m_st[0], m_st[1], m_st[2], m_rob, m_err); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_drain();
    test_partial();
    test_order();
    test_no_bypass();
    test_overflow_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
